// File: rtl/synapse_integrator.sv
// Spike-event integrator: FIFO-buffered IDs are weighted and summed into a saturating 16-bit current.
// Optional leak toward zero is compiled in when SYN_DECAY_EN is defined.
module synapse_integrator #(
   parameter int FIFO_DEPTH   = 4,
   parameter int NUM_W        = 16,
   parameter int DECAY_PERIOD = 8,
   parameter int DECAY_SHIFT  = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_spike_id,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [15:0] wr_data,
   output logic [15:0] current_out,
   output logic        sat,
   output logic [7:0]  drop_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = (NUM_W > 1) ? $clog2(NUM_W) : 1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || NUM_W < 2 ||
       DECAY_PERIOD < 1 || DECAY_SHIFT < 0 || DECAY_SHIFT > 15) begin : g_cfg_check
      $error("synapse_integrator: illegal parameter set");
   end

   function automatic logic [15:0] sat16(input logic [16:0] v);
      return v[16] ? 16'hFFFF : v[15:0];
   endfunction

   logic [IW-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] fifo_count;
   logic [15:0]   weight [NUM_W];
   logic [15:0]   acc;
   logic [15:0]   leak_base;
   logic [15:0]   head_w;
   logic [16:0]   acc_sum;
   logic [15:0]   acc_next;
   logic          sat_hit;
   logic          accept;
   logic          id_in_range;
   logic          push;
   logic          drop;
   logic          pop;
   logic          wr_in_range;

   assign in_ready    = (fifo_count != CW'(FIFO_DEPTH));
   assign accept      = in_valid && in_ready;
   assign id_in_range = (32'(in_spike_id) < 32'(NUM_W));
   assign push        = accept && (in_spike_id != 8'd0) && id_in_range;
   assign drop        = accept && (in_spike_id != 8'd0) && !id_in_range;
   assign pop         = (fifo_count != {CW{1'b0}});
   assign wr_in_range = (32'(wr_addr) < 32'(NUM_W));
   assign current_out = acc;

`ifdef SYN_DECAY_EN
   localparam int DW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
   logic [DW-1:0] decay_cnt;
   logic          leak;

   assign leak      = (decay_cnt == DW'(DECAY_PERIOD - 1));
   assign leak_base = leak ? (acc - (acc >> DECAY_SHIFT)) : acc;

   // Free-running leak timer; the wrap cycle triggers one decay step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         decay_cnt <= {DW{1'b0}};
      end else if (leak) begin
         decay_cnt <= {DW{1'b0}};
      end else begin
         decay_cnt <= decay_cnt + DW'(1);
      end
   end
`else
   assign leak_base = acc;
`endif

   // Leak (if any) is applied before the weighted add, then the sum saturates.
   always_comb begin
      head_w = weight[fifo_mem[rd_ptr]];
      if (pop) begin
         acc_sum = {1'b0, leak_base} + {1'b0, head_w};
      end else begin
         acc_sum = {1'b0, leak_base};
      end
      acc_next = sat16(acc_sum);
      sat_hit  = acc_sum[16];
   end

   // Event FIFO: pointers, occupancy and storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr     <= {AW{1'b0}};
         wr_ptr     <= {AW{1'b0}};
         fifo_count <= {CW{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= {IW{1'b0}};
         end
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= IW'(in_spike_id);
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Weight table; a pop reads the pre-write value in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_W; i++) begin
            weight[i] <= 16'd0;
         end
      end else if (wr_en && wr_in_range) begin
         weight[IW'(wr_addr)] <= wr_data;
      end
   end

   // Accumulator, sticky saturation flag and saturating drop counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc      <= 16'd0;
         sat      <= 1'b0;
         drop_cnt <= 8'd0;
      end else begin
         acc <= acc_next;
         if (sat_hit) begin
            sat <= 1'b1;
         end
         if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_synapse_integrator.sv
// Scoreboard bench for synapse_integrator: a queue-based reference model predicts the
// outputs after every rising edge and an independent monitor compares them.
module tb_synapse_integrator;

   localparam int FIFO_DEPTH   = 4;
   localparam int NUM_W        = 16;
   localparam int DECAY_PERIOD = 8;
   localparam int DECAY_SHIFT  = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_spike_id = 8'd0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = 4'd0;
   logic [15:0] wr_data = 16'd0;
   logic [15:0] current_out;
   logic        sat;
   logic [7:0]  drop_cnt;

   typedef struct {
      int cur;
      int sat;
      int drop;
      int rdy;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // reference model state
   int m_acc  = 0;
   int m_sat  = 0;
   int m_drop = 0;
   int m_dcnt = 0;
   int m_w [NUM_W];
   int m_q[$];

   synapse_integrator #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .NUM_W       (NUM_W),
      .DECAY_PERIOD(DECAY_PERIOD),
      .DECAY_SHIFT (DECAY_SHIFT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_spike_id(in_spike_id),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .current_out(current_out),
      .sat        (sat),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, expv, $time);
      end
   endtask

   // Reference model: one step per rising edge, from the behavioural rules.
   initial begin
      for (int i = 0; i < NUM_W; i++) m_w[i] = 0;
      forever begin
         exp_t e;
         int   base;
         int   w;
         int   id;
         bit   rdy;
         bit   has_pop;
         @(posedge clk);
         if (reset) begin
            m_acc = 0; m_sat = 0; m_drop = 0; m_dcnt = 0;
            m_q.delete();
            for (int i = 0; i < NUM_W; i++) m_w[i] = 0;
         end else begin
            rdy     = (m_q.size() != FIFO_DEPTH);
            has_pop = (m_q.size() > 0);
            w       = 0;
            if (has_pop) begin
               id = m_q.pop_front();
               w  = m_w[id];
            end
            base = m_acc;
`ifdef SYN_DECAY_EN
            if (m_dcnt == DECAY_PERIOD - 1) base = m_acc - m_acc / (2 ** DECAY_SHIFT);
            m_dcnt = (m_dcnt + 1) % DECAY_PERIOD;
`endif
            if (base + w > 65535) begin
               m_acc = 65535;
               m_sat = 1;
            end else begin
               m_acc = base + w;
            end
            if (in_valid && rdy) begin
               if (in_spike_id == 8'd0) begin
                  // discarded silently
               end else if (int'(in_spike_id) >= NUM_W) begin
                  if (m_drop < 255) m_drop++;
               end else begin
                  m_q.push_back(int'(in_spike_id));
               end
            end
            if (wr_en && int'(wr_addr) < NUM_W) m_w[wr_addr] = int'(wr_data);
         end
         e.cur  = m_acc;
         e.sat  = m_sat;
         e.drop = m_drop;
         e.rdy  = (m_q.size() != FIFO_DEPTH) ? 1 : 0;
         exp_q.push_back(e);
      end
   end

   // Monitor: after every edge, pop one prediction and compare all outputs.
   initial begin
      forever begin
         exp_t e;
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("current_out", 32'(current_out), 32'(e.cur));
            check("sat",         32'(sat),         32'(e.sat));
            check("drop_cnt",    32'(drop_cnt),    32'(e.drop));
            check("in_ready",    32'(in_ready),    32'(e.rdy));
         end
      end
   end

   task automatic cyc(input logic v, input logic [7:0] id,
                      input logic we, input logic [3:0] wa, input logic [15:0] wd);
      in_valid    = v;
      in_spike_id = id;
      wr_en       = we;
      wr_addr     = wa;
      wr_data     = wd;
      @(negedge clk);
   endtask

   task automatic ev(input logic [7:0] id);
      cyc(1'b1, id, 1'b0, 4'd0, 16'd0);
   endtask

   task automatic wr(input logic [3:0] wa, input logic [15:0] wd);
      cyc(1'b0, 8'd0, 1'b1, wa, wd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b0, 4'd0, 16'd0);
   endtask

   initial begin
      @(negedge clk);
      ev(8'd1);                          // handshake during reset must be ignored
      reset = 1'b0;
      check("reset_current", 32'(current_out), 32'd0);
      check("reset_ready",   32'(in_ready),    32'd1);

      // single event with weight 10
      wr(4'd1, 16'd10);
      idle(1);
      ev(8'd1);
      idle(3);

      // 0x4000 steps up to saturation
      wr(4'd2, 16'h4000);
      for (int i = 0; i < 5; i++) ev(8'd2);
      idle(3);

      // certain saturation regardless of leak
      wr(4'd3, 16'hFFFF);
      ev(8'd3);
      ev(8'd3);
      idle(1);
      check("sat_sticky", 32'(sat), 32'd1);

      // ID 0 discarded, ID 20 dropped
      ev(8'd0);
      ev(8'd20);
      idle(2);

      // weight write coinciding with a pop of the same index
      ev(8'd4);
      cyc(1'b1, 8'd4, 1'b1, 4'd4, 16'd100);
      idle(2);

      // drop counter saturates at 255
      for (int i = 0; i < 300; i++) ev(8'(16 + (i % 240)));
      idle(1);
      check("drop_saturate", 32'(drop_cnt), 32'd255);

      // asynchronous reset between edges with state built up
      wr(4'd6, 16'd500);
      ev(8'd6);
      idle(1);
      in_valid    = 1'b1;
      in_spike_id = 8'd6;
      #2 reset = 1'b1;
      #1;
      check("async_current", 32'(current_out), 32'd0);
      check("async_sat",     32'(sat),         32'd0);
      check("async_drop",    32'(drop_cnt),    32'd0);
      check("async_ready",   32'(in_ready),    32'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      ev(8'd1);                          // weights cleared: adds 0
      idle(2);
      check("post_reset_zero_weight", 32'(current_out), 32'd0);

      // load 800 and go idle so the leak (if built) can be observed
      wr(4'd5, 16'd800);
      ev(8'd5);
      idle(30);
      // continuous traffic so pops coincide with leak wraps
      for (int i = 0; i < 40; i++) ev(8'd5);
      idle(4);

      // randomized phase with occasional resets
      for (int i = 0; i < 1500; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (i % 400 == 399) begin
            reset = 1'b1;
            idle(2);
            reset = 1'b0;
         end
         if (r < 10) begin
            wr(4'($urandom_range(0, 15)), 16'($urandom_range(0, 255)));
         end else if (r < 15) begin
            cyc(1'b1, 8'($urandom_range(16, 255)), 1'b1, 4'($urandom_range(0, 15)),
                16'($urandom_range(0, 65535)));
         end else if (r < 70) begin
            cyc(1'b1, 8'($urandom_range(0, 15)), 1'b0, 4'd0, 16'd0);
         end else begin
            idle(1);
         end
      end
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
